// File: rtl/alu_pkg.sv
// Shared definitions for the UART ALU packet path: opcodes, header size, parser states.
package alu_pkg;

  localparam int HEADER_BYTES = 4;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h10,
    OP_MUL  = 8'h11,
    OP_DIV  = 8'h12,
    OP_ECHO = 8'hEC
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_EMIT,
    ST_DRAIN
  } parser_state_e;

  function automatic logic is_arith(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_valid_op(input logic [7:0] op);
    return is_arith(op) || (op == OP_ECHO);
  endfunction

endpackage

// File: rtl/uart_alu_parser_if.sv
// Byte stream in from UART RX and assembled ALU units out, plus the error pulse.
interface uart_alu_parser_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int OPERAND_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]    s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [7:0]               m_op_o;
  logic [OPERAND_WIDTH-1:0] m_operand_o;
  logic                     m_echo_o;
  logic                     m_first_o;
  logic                     m_last_o;
  logic                     m_valid_o;
  logic                     m_ready_i;
  logic                     err_o;

  // master: byte source and unit sink around the parser
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_ready_i,
    input  s_axis_tready, m_op_o, m_operand_o, m_echo_o,
           m_first_o, m_last_o, m_valid_o, err_o
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_ready_i,
    output s_axis_tready, m_op_o, m_operand_o, m_echo_o,
           m_first_o, m_last_o, m_valid_o, err_o
  );
endinterface

// File: rtl/operand_assembler.sv
// Little-endian byte-position shift register; done_o flags the byte that completes a unit.
module operand_assembler #(
  parameter int DATA_WIDTH    = 8,
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     vld_i,
  input  logic                     single_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  output logic [OPERAND_WIDTH-1:0] data_o,
  output logic                     done_o
);
  localparam int BYTES = OPERAND_WIDTH / DATA_WIDTH;
  localparam int PW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [PW-1:0] pos;

  // single_i: every byte is its own unit, zero-extended
  assign done_o = vld_i && (single_i || (pos == PW'(BYTES - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= '0;
      data_o <= '0;
    end else if (clr_i) begin
      pos <= '0;
    end else if (vld_i) begin
      if (pos == '0) data_o <= OPERAND_WIDTH'(data_i);
      else           data_o[int'(pos)*DATA_WIDTH +: DATA_WIDTH] <= data_i;
      pos <= done_o ? '0 : pos + 1'b1;
    end
  end
endmodule

// File: rtl/uart_alu_parser.sv
// Decodes 4-byte ALU headers from the UART byte stream and emits operand / echo units.
module uart_alu_parser
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int OPERAND_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  uart_alu_parser_if.slave bus
);
  localparam logic [15:0] HDR   = 16'(HEADER_BYTES);
  localparam logic [15:0] BPO16 = 16'(OPERAND_WIDTH / DATA_WIDTH);

  parser_state_e            state;
  logic [7:0]               len_lo;
  logic [15:0]              rem, rem_nxt, len_w, p_w;
  logic                     first_pend;
  logic                     acc, asm_done;
  logic [OPERAND_WIDTH-1:0] asm_data;

  assign acc     = bus.s_axis_tvalid && bus.s_axis_tready;
  assign len_w   = {bus.s_axis_tdata[7:0], len_lo};
  assign p_w     = len_w - HDR;
  assign rem_nxt = (rem != 16'd0) ? rem - 16'd1 : rem;

  operand_assembler #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPERAND_WIDTH(OPERAND_WIDTH)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (acc && state == ST_LEN_HI),
    .vld_i   (acc && state == ST_PAYLOAD),
    .single_i(bus.m_op_o == OP_ECHO),
    .data_i  (bus.s_axis_tdata),
    .data_o  (asm_data),
    .done_o  (asm_done)
  );

  // assembler register is frozen during EMIT since no bytes are accepted there
  assign bus.m_operand_o = asm_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      bus.s_axis_tready <= 1'b1;
      bus.m_valid_o     <= 1'b0;
      bus.m_first_o     <= 1'b0;
      bus.m_last_o      <= 1'b0;
      bus.m_echo_o      <= 1'b0;
      bus.m_op_o        <= 8'h00;
      bus.err_o         <= 1'b0;
      len_lo            <= 8'h00;
      rem               <= 16'd0;
      first_pend        <= 1'b0;
    end else begin
      bus.err_o <= 1'b0;
      case (state)
        ST_IDLE: if (acc) begin
          bus.m_op_o <= bus.s_axis_tdata[7:0];
          state      <= ST_RSVD;
        end
        ST_RSVD: if (acc) state <= ST_LEN_LO;
        ST_LEN_LO: if (acc) begin
          len_lo <= bus.s_axis_tdata[7:0];
          state  <= ST_LEN_HI;
        end
        ST_LEN_HI: if (acc) begin
          first_pend <= 1'b1;
          rem        <= p_w;
          if (len_w < HDR) begin
            rem       <= 16'd0;
            bus.err_o <= 1'b1;
            state     <= ST_IDLE;
          end else if (p_w == 16'd0) begin
            state <= ST_IDLE;
          end else if (!is_valid_op(bus.m_op_o) ||
                       (is_arith(bus.m_op_o) && (p_w % BPO16) != 16'd0)) begin
            state <= ST_DRAIN;
          end else begin
            state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: if (acc) begin
          rem <= rem_nxt;
          if (asm_done) begin
            bus.m_valid_o     <= 1'b1;
            bus.m_first_o     <= first_pend;
            bus.m_last_o      <= (rem_nxt == 16'd0);
            bus.m_echo_o      <= (bus.m_op_o == OP_ECHO);
            bus.s_axis_tready <= 1'b0;
            first_pend        <= 1'b0;
            state             <= ST_EMIT;
          end
        end
        ST_EMIT: if (bus.m_ready_i) begin
          bus.m_valid_o     <= 1'b0;
          bus.s_axis_tready <= 1'b1;
          state             <= (rem == 16'd0) ? ST_IDLE : ST_PAYLOAD;
        end
        ST_DRAIN: if (acc) begin
          rem <= rem_nxt;
          if (rem_nxt == 16'd0) begin
            bus.err_o <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_parser.sv
// Randomized packet bench for uart_alu_parser with a packet-level reference model.
module tb_uart_alu_parser;
  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] operand;
    logic        echo;
    logic        first;
    logic        last;
  } unit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_alu_parser_if #(.DATA_WIDTH(8), .OPERAND_WIDTH(32)) bus ();

  uart_alu_parser #(.DATA_WIDTH(8), .OPERAND_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int    pass_cnt = 0, total_cnt = 0;
  int    err_seen = 0, err_exp_total = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  int    gap_max  = 0;
  logic [7:0] pkt_q[$];
  unit_t exp_q[$], got_q[$];
  unit_t cur, held, e;
  logic  was_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Expected units and error flag computed straight from the packet bytes.
  function automatic int model_packet();
    logic [7:0] op;
    int len, p;
    bit arith;
    op    = pkt_q[0];
    len   = int'(pkt_q[2]) + (int'(pkt_q[3]) << 8);
    if (len < 4) return 1;
    p     = len - 4;
    if (p == 0) return 0;
    arith = op inside {8'h10, 8'h11, 8'h12};
    if (!(arith || op == 8'hEC) || (arith && (p % 4) != 0)) return 1;
    if (op == 8'hEC) begin
      for (int i = 0; i < p; i++)
        exp_q.push_back('{op, {24'h0, pkt_q[4+i]}, 1'b1, i == 0, i == p - 1});
    end else begin
      for (int k = 0; k < p / 4; k++)
        exp_q.push_back('{op, {pkt_q[7+4*k], pkt_q[6+4*k], pkt_q[5+4*k], pkt_q[4+4*k]},
                          1'b0, k == 0, k == p / 4 - 1});
    end
    return 0;
  endfunction

  // Output driver: changes just after each rising edge.
  initial begin
    bus.m_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.m_ready_i = 1'b1;
        1:       bus.m_ready_i = ($urandom_range(0, 9) < 7);
        default: bus.m_ready_i = 1'b0;
      endcase
    end
  end

  // Single compare process: handshake, stability and unit contents.
  always @(negedge clk) begin
    if (rst) begin
      was_stall = 1'b0;
    end else begin
      chk("tready_vs_valid", bus.s_axis_tready, !bus.m_valid_o);
      if (bus.err_o) err_seen++;
      if (bus.m_valid_o) begin
        cur = '{bus.m_op_o, bus.m_operand_o, bus.m_echo_o, bus.m_first_o, bus.m_last_o};
        if (was_stall) chk("stall_stable", cur, held);
        if (bus.m_ready_i) begin
          chk("unit_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("unit", cur, e);
          end
          got_q.push_back(cur);
        end
        was_stall = !bus.m_ready_i;
        held      = cur;
      end else begin
        was_stall = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    logic rdy;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    bus.s_axis_tdata  = b;
    bus.s_axis_tvalid = 1'b1;
    g = 0;
    do begin
      rdy = bus.s_axis_tready;
      @(negedge clk);
      g++;
    end while (!rdy && g < 400);
    bus.s_axis_tvalid = 1'b0;
    chk("byte_accepted", rdy, 1);
  endtask

  task automatic send_packet();
    int ee;
    ee = model_packet();
    err_exp_total += ee;
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    chk("err_after_pkt", bus.err_o, ee[0]);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || bus.m_valid_o) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain_in_time", g < 500, 1);
  endtask

  task automatic chk_unit(input string n, input int idx, input unit_t req);
    if (idx < got_q.size()) chk(n, got_q[idx], req);
    else chk({n, "_missing"}, got_q.size(), idx + 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_tready",  bus.s_axis_tready, 1);
    chk("rst_valid",   bus.m_valid_o, 0);
    chk("rst_first",   bus.m_first_o, 0);
    chk("rst_last",    bus.m_last_o, 0);
    chk("rst_echo",    bus.m_echo_o, 0);
    chk("rst_err",     bus.err_o, 0);
    chk("rst_op",      bus.m_op_o, 0);
    chk("rst_operand", bus.m_operand_o, 0);
  endtask

  task automatic gen_random();
    logic [7:0]  op;
    logic [15:0] len;
    int k, p;
    pkt_q.delete();
    k = $urandom_range(0, 9);
    if (k < 3) begin
      op = 8'hEC; p = $urandom_range(0, 6);
    end else if (k < 8) begin
      op = 8'h10 + 8'($urandom_range(0, 2));
      p  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 4 * $urandom_range(0, 3);
    end else begin
      op = 8'($urandom);
      if (op inside {8'h10, 8'h11, 8'h12, 8'hEC}) op = 8'h55;
      p = $urandom_range(0, 5);
    end
    len = 16'(p + 4);
    if ($urandom_range(0, 11) == 0) begin
      len = 16'($urandom_range(0, 3));
      p   = 0;
    end
    pkt_q = '{op, 8'($urandom), len[7:0], len[15:8]};
    for (int i = 0; i < p; i++) pkt_q.push_back(8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // echo
    got_q.delete();
    pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    send_packet(); wait_drain();
    chk("echo_count", got_q.size(), 2);
    chk_unit("echo_u0", 0, '{8'hEC, 32'h41, 1'b1, 1'b1, 1'b0});
    chk_unit("echo_u1", 1, '{8'hEC, 32'h42, 1'b1, 1'b0, 1'b1});

    // add
    got_q.delete();
    pkt_q = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_packet(); wait_drain();
    chk_unit("add_u0", 0, '{8'h10, 32'h1, 1'b0, 1'b1, 1'b0});
    chk_unit("add_u1", 1, '{8'h10, 32'h2, 1'b0, 1'b0, 1'b1});

    // backpressure on the same add packet
    got_q.delete();
    rdy_mode = 2;
    fork
      send_packet();
      begin
        int g = 0;
        while (!bus.m_valid_o && g < 200) begin @(negedge clk); g++; end
        chk("bp_valid_seen", bus.m_valid_o, 1);
        repeat (10) begin
          @(negedge clk);
          chk("bp_tready", bus.s_axis_tready, 0);
          chk("bp_operand", bus.m_operand_o, 32'h1);
        end
        rdy_mode = 0;
      end
    join
    wait_drain();
    chk_unit("bp_u0", 0, '{8'h10, 32'h1, 1'b0, 1'b1, 1'b0});
    chk_unit("bp_u1", 1, '{8'h10, 32'h2, 1'b0, 1'b0, 1'b1});

    // bad opcode, then echo
    got_q.delete();
    pkt_q = '{8'h55, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_packet();
    chk("badop_err", bus.err_o, 1);
    @(negedge clk);
    chk("badop_err_once", bus.err_o, 0);
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    send_packet(); wait_drain();
    chk("badop_count", got_q.size(), 1);
    chk_unit("badop_echo", 0, '{8'hEC, 32'h7E, 1'b1, 1'b1, 1'b1});

    // bad lengths
    pkt_q = '{8'h11, 8'h00, 8'h03, 8'h00};
    send_packet();
    chk("len3_err", bus.err_o, 1);
    pkt_q = '{8'h11, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_packet();
    chk("len6_err", bus.err_o, 1);
    wait_drain();

    // reset mid-payload
    pkt_q = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    send_packet(); wait_drain();
    chk_unit("post_rst_echo", 0, '{8'hEC, 32'h7E, 1'b1, 1'b1, 1'b1});

    // randomized traffic
    rdy_mode = 1;
    gap_max  = 2;
    for (int n = 0; n < 60; n++) begin
      gen_random();
      send_packet();
    end
    wait_drain();
    repeat (3) @(negedge clk);
    chk("err_pulse_total", err_seen, err_exp_total);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
